// File: rtl/rv_pipe_pkg.sv
// Shared pipeline package for the RV core front end.
// Holds the legal NOP that is shown to ID when no real instruction exists,
// default datapath widths, and the fetch FSM state encoding.
// No ports (package).
package rv_pipe_pkg;

  localparam int INST_LENGTH_DEF = 32;
  localparam int PC_LENGTH_DEF   = 32;

  // add x0, x0, x0 -- architecturally a no-op
  localparam logic [31:0] NOP_INST = 32'h00000033;

  // IDLE : free to issue a request when a buffer slot is guaranteed
  // REQ  : one request outstanding, its data will be kept
  // KILL : one request outstanding, its data will be dropped (redirect seen)
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction memory fetch bus.
// Signals:
//   imem_req   fetch request, held high until imem_ack
//   imem_addr  fetch address, stable while imem_req is high
//   imem_ack   one-cycle pulse, imem_rdata valid in that cycle
//   imem_rdata fetched word
// Modports: master (fetch unit side), slave (memory side).
interface if_fetch_unit_if #(
  parameter int INST_LENGTH = 32,
  parameter int PC_LENGTH   = 32
) ();

  logic                   imem_req;
  logic [PC_LENGTH-1:0]   imem_addr;
  logic                   imem_ack;
  logic [INST_LENGTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_prefetch_fifo.sv
// Small synchronous prefetch FIFO used by the fetch unit.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data at the tail
//   pop          discard the head entry
//   flush        empty the FIFO; overrides push and pop in the same cycle
//   push_data    entry to write
//   head_data    current head entry (meaningless while count == 0)
//   count        number of valid entries, 0..DEPTH
// The producer guarantees it never pushes into a full FIFO.
module if_prefetch_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
  // pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is only looked at when count != 0.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage instruction fetch unit.
// Owns the PC, fetches one word at a time from instruction memory, buffers
// fetched words and presents {inst_hat, PC_hat} to the IF/ID register.
// A redirect (PCSel) flushes the buffer and drops any in-flight fetch.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   imem          fetch bus (master modport)
//   PCSel         redirect from EX; pc_target sampled when high
//   pc_target     redirect address
//   stall         ID not accepting, hold the head entry
//   inst_hat      head instruction, NOP when fetch_valid=0
//   PC_hat        head PC, 0 when fetch_valid=0
//   fetch_valid   head entry is real
//   perf_fetched  (FETCH_PERF_EN only) number of words pushed, saturating
//   perf_bubbles  (FETCH_PERF_EN only) cycles with no valid head and no stall
// Optional feature macro: FETCH_PERF_EN.
module if_fetch_unit
  import rv_pipe_pkg::*;
#(
  parameter int                 INST_LENGTH = INST_LENGTH_DEF,
  parameter int                 PC_LENGTH   = PC_LENGTH_DEF,
  parameter int                 FIFO_DEPTH  = 2,
  parameter logic [PC_LENGTH-1:0] RESET_PC  = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  if_fetch_unit_if.master        imem,
  input  logic                   PCSel,
  input  logic [PC_LENGTH-1:0]   pc_target,
  input  logic                   stall,
  output logic [INST_LENGTH-1:0] inst_hat,
  output logic [PC_LENGTH-1:0]   PC_hat,
  output logic                   fetch_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_bubbles
`endif
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = INST_LENGTH + PC_LENGTH;

  fetch_state_e         state, state_n;
  logic [PC_LENGTH-1:0] pc_next, pc_next_n;
  logic [PC_LENGTH-1:0] addr_q, addr_q_n;
  logic                 push, pop, flush;
  logic [CNT_W-1:0]     count;
  logic [ENTRY_W-1:0]   head;

  if_prefetch_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data ({imem.imem_rdata, addr_q}),
    .head_data (head),
    .count     (count)
  );

  // FSM state, next fetch PC and the latched request address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc_next <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state   <= state_n;
      pc_next <= pc_next_n;
      addr_q  <= addr_q_n;
    end
  end

  // Next-state logic. A request is only issued from IDLE when a slot is free,
  // and only one request is ever outstanding, so the push cannot overflow.
  // addr_q holds the request address so it stays stable in KILL even though
  // pc_next may already point at the redirect target.
  always_comb begin
    state_n   = state;
    pc_next_n = pc_next;
    addr_q_n  = addr_q;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (PCSel) begin
          pc_next_n = pc_target;
        end else if (count < CNT_W'(FIFO_DEPTH)) begin
          addr_q_n = pc_next;
          state_n  = REQ;
        end
      end
      REQ: begin
        if (PCSel) begin
          pc_next_n = pc_target;
          state_n   = imem.imem_ack ? IDLE : KILL;
        end else if (imem.imem_ack) begin
          push      = 1'b1;
          pc_next_n = pc_next + PC_LENGTH'(4);
          state_n   = IDLE;
        end
      end
      KILL: begin
        if (PCSel) pc_next_n = pc_target;
        if (imem.imem_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign flush       = PCSel;
  assign fetch_valid = (count != '0);
  assign pop         = fetch_valid && !stall && !PCSel;

  assign imem.imem_req  = (state == REQ) || (state == KILL);
  assign imem.imem_addr = addr_q;

  assign inst_hat = fetch_valid ? head[ENTRY_W-1:PC_LENGTH] : INST_LENGTH'(NOP_INST);
  assign PC_hat   = fetch_valid ? head[PC_LENGTH-1:0]       : '0;

`ifdef FETCH_PERF_EN
  // Saturating performance counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (push && (perf_fetched != 32'hFFFF_FFFF))
        perf_fetched <= perf_fetched + 32'd1;
      if (!fetch_valid && !stall && (perf_bubbles != 32'hFFFF_FFFF))
        perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit.
// Instance A (RESET_PC=0) runs reset, streaming, stall, redirect and
// reset-mid-request scenarios against a latency-configurable memory model that
// returns addr ^ 32'hA5A5A5A5. Expected PCs are queued per scenario and
// compared whenever ID consumes the head. Instance B (RESET_PC=FFFFFFFC)
// covers the PC wrap. Build with FETCH_PERF_EN to include the counters.
module tb_if_fetch_unit;
  import rv_pipe_pkg::*;

  localparam logic [31:0] XOR_KEY  = 32'hA5A5A5A5;
  localparam logic [31:0] BAD_WORD = 32'hBAD0BAD0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A stimulus and outputs
  logic        pc_sel    = 1'b0;
  logic [31:0] pc_target = '0;
  logic        stall     = 1'b0;
  logic [31:0] inst_hat, pc_hat;
  logic        fetch_valid;

  // Instance B stimulus and outputs
  logic        pc_sel_b    = 1'b0;
  logic [31:0] pc_target_b = '0;
  logic        stall_b     = 1'b1;
  logic [31:0] inst_hat_b, pc_hat_b;
  logic        fetch_valid_b;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_a, perf_bubbles_a;
  logic [31:0] perf_fetched_b, perf_bubbles_b;
`endif

  if_fetch_unit_if #(.INST_LENGTH(32), .PC_LENGTH(32)) bus_a ();
  if_fetch_unit_if #(.INST_LENGTH(32), .PC_LENGTH(32)) bus_b ();

  // Memory model A: acks once the request has waited lat_a cycles;
  // force_ack injects a stray ack carrying a poison word.
  int   lat_a     = 0;
  int   wait_a    = 0;
  logic force_ack = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)               wait_a <= 0;
    else if (bus_a.imem_ack)  wait_a <= 0;
    else if (bus_a.imem_req)  wait_a <= wait_a + 1;
  end
  assign bus_a.imem_ack   = force_ack || (bus_a.imem_req && (wait_a >= lat_a));
  assign bus_a.imem_rdata = force_ack ? BAD_WORD : (bus_a.imem_addr ^ XOR_KEY);

  // Memory model B: same-cycle ack
  assign bus_b.imem_ack   = bus_b.imem_req;
  assign bus_b.imem_rdata = bus_b.imem_addr ^ XOR_KEY;

  if_fetch_unit #(.INST_LENGTH(32), .PC_LENGTH(32), .FIFO_DEPTH(2),
                  .RESET_PC(32'h00000000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (bus_a),
    .PCSel       (pc_sel),
    .pc_target   (pc_target),
    .stall       (stall),
    .inst_hat    (inst_hat),
    .PC_hat      (pc_hat),
    .fetch_valid (fetch_valid)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched_a),
    .perf_bubbles (perf_bubbles_a)
`endif
  );

  if_fetch_unit #(.INST_LENGTH(32), .PC_LENGTH(32), .FIFO_DEPTH(2),
                  .RESET_PC(32'hFFFFFFFC)) dut_wrap (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (bus_b),
    .PCSel       (pc_sel_b),
    .pc_target   (pc_target_b),
    .stall       (stall_b),
    .inst_hat    (inst_hat_b),
    .PC_hat      (pc_hat_b),
    .fetch_valid (fetch_valid_b)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched_b),
    .perf_bubbles (perf_bubbles_b)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sel, input logic [31:0] target,
                               input logic stl);
    pc_sel    = sel;
    pc_target = target;
    stall     = stl;
  endtask

  task automatic cycleStep();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: expected PCs of instance A, popped whenever ID consumes.
  logic [31:0] exp_q[$];
  logic        mon_en = 1'b0;
  always @(negedge clk) begin
    logic [31:0] exp_pc;
    if (rst_n && mon_en && fetch_valid && !stall && !pc_sel) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_pc = exp_q.pop_front();
        checkOutput("pop_pc", pc_hat, exp_pc);
        checkOutput("pop_inst", inst_hat, exp_pc ^ XOR_KEY);
      end
    end
  end

  task automatic doReset();
    mon_en    = 1'b0;
    rst_n     = 1'b0;
    force_ack = 1'b0;
    stall_b   = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget; i++) begin
      cycleStep();
      if (exp_q.size() == 0) break;
    end
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
  endtask

  task automatic waitReq(input int budget);
    for (int i = 0; i < budget; i++) begin
      cycleStep();
      if (bus_a.imem_req) break;
    end
    checkOutput("req_seen", 32'(bus_a.imem_req), 32'd1);
  endtask

  initial begin
    // 1: reset values, then streaming on a 1-cycle memory
    applyStimulus(1'b0, 32'h0, 1'b0);
    #12;
    checkOutput("rst_req", 32'(bus_a.imem_req), 32'd0);
    checkOutput("rst_addr", bus_a.imem_addr, 32'h0);
    checkOutput("rst_inst", inst_hat, NOP_INST);
    checkOutput("rst_pc", pc_hat, 32'h0);
    checkOutput("rst_valid", 32'(fetch_valid), 32'd0);
    lat_a = 0;
    doReset();
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    waitDrain(100);

    // 2: stall fills the buffer and blocks requests, then back-to-back drain
    lat_a = 0;
    applyStimulus(1'b0, 32'h0, 1'b1);
    doReset();
    repeat (10) cycleStep();
    checkOutput("t2_req_full", 32'(bus_a.imem_req), 32'd0);
    checkOutput("t2_valid", 32'(fetch_valid), 32'd1);
    checkOutput("t2_hold_pc", pc_hat, 32'h0);
    checkOutput("t2_hold_inst", inst_hat, 32'h0 ^ XOR_KEY);
`ifdef FETCH_PERF_EN
    checkOutput("t2_perf_fetched", perf_fetched_a, 32'd2);
    checkOutput("t2_perf_bubbles", perf_bubbles_a, 32'd0);
`endif
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    applyStimulus(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("t2_b2b_first", pc_hat, 32'h0);
    @(negedge clk);
    checkOutput("t2_b2b_second", pc_hat, 32'h4);
    checkOutput("t2_b2b_valid", 32'(fetch_valid), 32'd1);
    waitDrain(100);

    // 3: redirect while a slow request is outstanding
    lat_a = 5;
    applyStimulus(1'b0, 32'h0, 1'b0);
    doReset();
    waitReq(20);
    repeat (2) cycleStep();
    applyStimulus(1'b1, 32'h100, 1'b0);
    cycleStep();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t3_kill_req", 32'(bus_a.imem_req), 32'd1);
    checkOutput("t3_kill_addr", bus_a.imem_addr, 32'h0);
    checkOutput("t3_kill_valid", 32'(fetch_valid), 32'd0);
    checkOutput("t3_kill_inst", inst_hat, NOP_INST);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    for (int i = 0; i < 50; i++) begin
      cycleStep();
      if (bus_a.imem_req && bus_a.imem_addr != 32'h0) break;
    end
    checkOutput("t3_new_addr", bus_a.imem_addr, 32'h100);
    waitDrain(100);

    // 4: redirect in the same cycle as the ack
    lat_a = 2;
    applyStimulus(1'b0, 32'h0, 1'b0);
    doReset();
    waitReq(20);
    repeat (2) cycleStep();
    applyStimulus(1'b1, 32'h200, 1'b0);
    cycleStep();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t4_idle_req", 32'(bus_a.imem_req), 32'd0);
    checkOutput("t4_valid", 32'(fetch_valid), 32'd0);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    waitReq(20);
    checkOutput("t4_new_addr", bus_a.imem_addr, 32'h200);
    waitDrain(100);

    // 5: reset mid-request, then a stray late ack while IDLE
    lat_a = 5;
    applyStimulus(1'b0, 32'h0, 1'b0);
    doReset();
    waitReq(20);
    cycleStep();
    #2;
    rst_n  = 1'b0;
    mon_en = 1'b0;
    #1;
    checkOutput("t5_rst_req", 32'(bus_a.imem_req), 32'd0);
    checkOutput("t5_rst_valid", 32'(fetch_valid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    lat_a     = 0;
    force_ack = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    mon_en    = 1'b1;
    cycleStep();
    force_ack = 1'b0;
    checkOutput("t5_restart_req", 32'(bus_a.imem_req), 32'd1);
    checkOutput("t5_restart_addr", bus_a.imem_addr, 32'h0);
    waitDrain(100);

    // 6: PC wrap on instance B
    applyStimulus(1'b0, 32'h0, 1'b1);
    doReset();
    repeat (8) cycleStep();
    checkOutput("t6_head_pc", pc_hat_b, 32'hFFFFFFFC);
    checkOutput("t6_head_inst", inst_hat_b, 32'hFFFFFFFC ^ XOR_KEY);
    checkOutput("t6_valid", 32'(fetch_valid_b), 32'd1);
    stall_b = 1'b0;
    cycleStep();
    stall_b = 1'b1;
    checkOutput("t6_wrap_pc", pc_hat_b, 32'h0);
    checkOutput("t6_wrap_inst", inst_hat_b, 32'h0 ^ XOR_KEY);
    repeat (6) cycleStep();
    checkOutput("t6_hold_pc", pc_hat_b, 32'h0);
`ifdef FETCH_PERF_EN
    checkOutput("t6_perf_fetched", perf_fetched_b, 32'd3);
    checkOutput("t6_perf_bubbles", perf_bubbles_b, 32'd0);
`endif
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
